alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_arbiter_rr_arb2.sv | 19 +
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, flag bit positions and the
// arbiter FSM state encoding.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_AND  = 5'h02;
    localparam logic [4:0] OP_OR   = 5'h03;
    localparam logic [4:0] OP_XOR  = 5'h04;
    localparam logic [4:0] OP_NOR  = 5'h05;
    localparam logic [4:0] OP_SLL  = 5'h06;
    localparam logic [4:0] OP_SRL  = 5'h07;
    localparam logic [4:0] OP_SRA  = 5'h08;
    localparam logic [4:0] OP_SLT  = 5'h09;
    localparam logic [4:0] OP_SLTU = 5'h0A;
    localparam logic [4:0] OP_LUI  = 5'h0B;
    localparam logic [4:0] OP_MUL  = 5'h0C;
    localparam logic [4:0] OP_MULH = 5'h0D;
    localparam logic [4:0] OP_DIV  = 5'h0E;
    localparam logic [4:0] OP_REM  = 5'h0F;
    localparam logic [4:0] OP_LB   = 5'h10;
    localparam logic [4:0] OP_LH   = 5'h11;
    localparam logic [4:0] OP_LW   = 5'h12;
    localparam logic [4:0] OP_SB   = 5'h13;

    // alu_flags = {carry, zero, overflow, negative}
    localparam int FLAG_NEG   = 0;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_CARRY = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: valid[1:0], prio (index favoured on a
// tie) -> one-hot grant, all-zero when nothing is valid.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters.
// Ports: req_* (2 requesters, packed), alu_* (to/from ALU),
// rsp_* (per-requester response), busy (FSM not idle).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit         INIT_PRIO = 1'b0,
    parameter logic [4:0] OP_MAX    = 5'h13
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [9:0]  req_shamt,
    input  logic [9:0]  req_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy
);

    state_e      state_q, state_d;
    logic        prio_q, prio_d;
    logic        owner_q, owner_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d;
    logic        err_q, err_d;

    logic [1:0]  grant;
    logic        gidx;
    logic        xfer;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [4:0]  sel_shamt;
    logic [4:0]  sel_op;

    rr_arb2 u_arb (
        .valid (req_valid),
        .prio  (prio_q),
        .grant (grant)
    );

    assign gidx      = grant[1];
    assign sel_a     = gidx ? req_a[63:32]    : req_a[31:0];
    assign sel_b     = gidx ? req_b[63:32]    : req_b[31:0];
    assign sel_shamt = gidx ? req_shamt[9:5]  : req_shamt[4:0];
    assign sel_op    = gidx ? req_op[9:5]     : req_op[4:0];

    assign req_ready = (state_q == ST_IDLE) ? grant : 2'b00;
    assign xfer      = |(req_valid & req_ready);

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        a_d      = a_q;
        b_d      = b_q;
        shamt_d  = shamt_q;
        op_d     = op_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    owner_d = gidx;
                    // Last winner yields the tie to the other side.
                    prio_d  = ~gidx;
                    if (sel_op > OP_MAX) begin
                        // ALU regs untouched: an illegal op never
                        // reaches the ALU.
                        result_d = '0;
                        flags_d  = '0;
                        err_d    = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        a_d     = sel_a;
                        b_d     = sel_b;
                        shamt_d = sel_shamt;
                        op_d    = sel_op;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                flags_d  = alu_flags;
                err_d    = 1'b0;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            prio_q   <= INIT_PRIO;
            owner_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            shamt_q  <= '0;
            op_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shamt_q  <= shamt_d;
            op_q     <= op_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_shamt  = shamt_q;
    assign alu_op     = op_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != ST_IDLE);
    assign rsp_valid  = (state_q != ST_RESP) ? 2'b00 :
                        (owner_q ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a small behavioural ALU
// attached to the alu_* ports.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [9:0]  req_shamt;
    logic [9:0]  req_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [4:0]  alu_op;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic        idx;
        logic [31:0] res;
        logic [3:0]  fl;
        logic        err;
    } exp_t;

    exp_t sb[$];

    alu_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_shamt  (req_shamt),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_shamt  (alu_shamt),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: flags = {carry, zero, overflow, negative}
    logic [32:0] m_sum;
    logic [31:0] m_res;
    logic        m_c;
    logic        m_v;
    always_comb begin
        m_sum = '0;
        m_res = '0;
        m_c   = 1'b0;
        m_v   = 1'b0;
        case (alu_op)
            OP_ADD: begin
                m_sum = {1'b0, alu_a} + {1'b0, alu_b};
                m_res = m_sum[31:0];
                m_c   = m_sum[32];
                m_v   = (alu_a[31] == alu_b[31]) && (m_res[31] != alu_a[31]);
            end
            OP_SUB: begin
                m_res = alu_a - alu_b;
                m_c   = (alu_a < alu_b);
                m_v   = (alu_a[31] != alu_b[31]) && (m_res[31] != alu_a[31]);
            end
            OP_XOR: m_res = alu_a ^ alu_b;
            OP_SRA: m_res = $signed(alu_a) >>> alu_shamt;
            default: m_res = '0;
        endcase
        alu_result = m_res;
        alu_flags  = {m_c, (m_res == 32'd0), m_v, m_res[31]};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        tests++;
        failed++;
        $display("FAIL %s: timeout got no event expected event", name);
    endtask

    task automatic push(input logic idx, input logic [31:0] res, input logic [3:0] fl, input logic err);
        exp_t e;
        e.idx = idx;
        e.res = res;
        e.fl  = fl;
        e.err = err;
        sb.push_back(e);
    endtask

    // Response monitor: compares on every response handshake.
    always @(negedge clk) begin
        logic [1:0] hs;
        exp_t e;
        hs = rsp_valid & rsp_ready;
        if (reset_n && hs != 2'b00) begin
            if (sb.size() == 0) begin
                fail_timeout("unexpected_rsp");
            end else begin
                e = sb.pop_front();
                chk("rsp_owner", {62'd0, hs}, {62'd0, (e.idx ? 2'b10 : 2'b01)});
                chk("rsp_result", {32'd0, rsp_result}, {32'd0, e.res});
                chk("rsp_flags", {60'd0, rsp_flags}, {60'd0, e.fl});
                chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
            end
        end
    end

    task automatic set_req(input logic idx, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
        if (idx) begin
            req_a[63:32]   = a;
            req_b[63:32]   = b;
            req_op[9:5]    = op;
            req_shamt[9:5] = sh;
        end else begin
            req_a[31:0]    = a;
            req_b[31:0]    = b;
            req_op[4:0]    = op;
            req_shamt[4:0] = sh;
        end
    endtask

    task automatic wait_ready(input logic idx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                ok = 1'b1;
                return;
            end
        end
        fail_timeout("wait_ready");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        fail_timeout("wait_idle");
    endtask

    // Single request with latency checks; returns at the negedge
    // of the first RESP cycle.
    task automatic do_req(input logic idx, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input bit legal);
        bit ok;
        logic [1:0] oh;
        oh = idx ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        set_req(idx, op, a, b, sh);
        req_valid[idx] = 1'b1;
        wait_ready(idx, ok);
        if (!ok) begin
            req_valid[idx] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        @(negedge clk);
        if (legal) begin
            chk("lat_exec", {61'd0, busy, rsp_valid}, {61'd0, 1'b1, 2'b00});
            @(negedge clk);
        end
        chk("lat_rsp", {62'd0, rsp_valid}, {62'd0, oh});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: timeout got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_shamt = '0;
        req_op    = '0;
        rsp_ready = 2'b11;

        // Reset state
        #12;
        chk("rst_ctrl", {49'd0, req_ready, rsp_valid, busy, rsp_err, rsp_flags, alu_shamt},
            64'd0);
        chk("rst_result", {27'd0, alu_op, rsp_result}, 64'd0);
        chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Simultaneous: r0 SUB 3-3 wins (INIT_PRIO=0), then r1 XOR
        push(1'b0, 32'd0, 4'b0100, 1'b0);
        push(1'b1, 32'h0000_00FF, 4'b0000, 1'b0);
        set_req(1'b0, OP_SUB, 32'd3, 32'd3, 5'd0);
        set_req(1'b1, OP_XOR, 32'hF0, 32'h0F, 5'd0);
        req_valid = 2'b11;
        @(negedge clk);
        chk("grant_both", {62'd0, req_ready}, {62'd0, 2'b01});
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("exec_ready_low", {61'd0, req_ready, busy}, {61'd0, 2'b00, 1'b1});
        @(negedge clk);
        chk("resp_r0", {60'd0, rsp_valid, req_ready}, {60'd0, 2'b01, 2'b00});
        wait_ready(1'b1, ok);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_idle();

        // Prio back to r0; r0 ADD 5+7 with latency, r1 ADD 1+2
        push(1'b0, 32'd12, 4'b0000, 1'b0);
        push(1'b1, 32'd3, 4'b0000, 1'b0);
        @(posedge clk); #1;
        set_req(1'b0, OP_ADD, 32'd5, 32'd7, 5'd0);
        set_req(1'b1, OP_ADD, 32'd1, 32'd2, 5'd0);
        req_valid = 2'b11;
        @(negedge clk);
        chk("prio_back_r0", {62'd0, req_ready}, {62'd0, 2'b01});
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("add_n1", {61'd0, busy, rsp_valid}, {61'd0, 1'b1, 2'b00});
        @(negedge clk);
        chk("add_n2", {62'd0, rsp_valid}, {62'd0, 2'b01});
        wait_ready(1'b1, ok);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_idle();

        // Illegal op from r1: N+1 response, ALU untouched
        push(1'b1, 32'd0, 4'b0000, 1'b1);
        do_req(1'b1, 5'h1F, 32'hDEAD, 32'hBEEF, 5'd3, 1'b0);
        chk("illegal_alu", {alu_a, alu_b}, {32'd1, 32'd2});
        chk("illegal_alu_op", {54'd0, alu_op, alu_shamt}, {54'd0, OP_ADD, 5'd0});
        wait_idle();

        // Backpressure on r0 SRA, r1 request ignored meanwhile
        push(1'b0, 32'hF800_0000, 4'b0001, 1'b0);
        push(1'b1, 32'd5, 4'b0000, 1'b0);
        rsp_ready = 2'b10;
        do_req(1'b0, OP_SRA, 32'h8000_0000, 32'd0, 5'd4, 1'b1);
        set_req(1'b1, OP_ADD, 32'd2, 32'd3, 5'd0);
        req_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {rsp_result, 24'd0, rsp_flags, rsp_valid, req_ready},
                {32'hF800_0000, 24'd0, 4'b0001, 2'b01, 2'b00});
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        wait_ready(1'b1, ok);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_idle();

        // Signed overflow
        push(1'b0, 32'h8000_0000, 4'b0011, 1'b0);
        do_req(1'b0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1);
        wait_idle();

        // Reset while in EXEC discards the operation
        @(posedge clk); #1;
        set_req(1'b0, OP_ADD, 32'd9, 32'd9, 5'd0);
        req_valid[0] = 1'b1;
        wait_ready(1'b0, ok);
        @(posedge clk); #1;
        req_valid = 2'b00;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_exec_ctrl", {49'd0, req_ready, rsp_valid, busy, rsp_err, rsp_flags, alu_shamt},
            64'd0);
        chk("rst_exec_res", {27'd0, alu_op, rsp_result}, 64'd0);
        chk("rst_exec_ab", {alu_a, alu_b}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", {61'd0, rsp_valid, busy}, 64'd0);
        end
        push(1'b0, 32'd2, 4'b0000, 1'b0);
        do_req(1'b0, OP_ADD, 32'd1, 32'd1, 5'd0, 1'b1);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
